// File: rtl/branch_unit.sv
// ============================================================================
// branch_unit : elastic RISC-V conditional-branch resolver with retire stats.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_unit #(
   parameter int n      = 32,
   parameter int STAGES = 2,
   parameter int CNTW   = 16
) (
   input  logic            clock,
   input  logic            nReset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [n-1:0]    A,
   input  logic [n-1:0]    B,
   input  logic [2:0]      funct3,
   input  logic [n-1:0]    pc,
   input  logic [n-1:0]    imm,
   input  logic            pred_taken,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            taken,
   output logic [n-1:0]    next_pc,
   output logic            mispredict,
   output logic            illegal,
   output logic [CNTW-1:0] br_count,
   output logic [CNTW-1:0] mis_count
);

   localparam logic [n-1:0]    c_four = {{(n-3){1'b0}}, 3'b100};
   localparam logic [CNTW-1:0] c_one  = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] c_max  = '1;

   logic         w_eq, w_lt, w_ltu, w_cond;
   logic         w_illegal, w_taken, w_mispred;
   logic         w_adv1, w_ov, w_tk, w_ill, w_mis, w_retire;
   logic [n-1:0] w_npc;
   logic [CNTW-1:0] r_br, r_mis_cnt;

   always_comb begin
      w_eq      = (A == B);
      w_lt      = ($signed(A) < $signed(B));
      w_ltu     = (A < B);
      w_illegal = (funct3[2:1] == 2'b01);
      case (funct3)
         3'b000:  w_cond = w_eq;
         3'b001:  w_cond = !w_eq;
         3'b100:  w_cond = w_lt;
         3'b101:  w_cond = !w_lt;
         3'b110:  w_cond = w_ltu;
         3'b111:  w_cond = !w_ltu;
         default: w_cond = 1'b0;
      endcase
      w_taken   = w_cond && !w_illegal;
      w_mispred = (w_taken != pred_taken) && !w_illegal;
   end

   generate
      if (STAGES == 1) begin : g_one
         logic         r_v, r_tk, r_ill, r_mis;
         logic [n-1:0] r_npc;

         assign w_adv1 = !r_v || out_ready;

         always_ff @(posedge clock or negedge nReset) begin
            if (!nReset)      r_v <= 1'b0;
            else if (flush)   r_v <= 1'b0;
            else if (w_adv1)  r_v <= in_valid;
         end

         always_ff @(posedge clock) begin
            if (w_adv1 && in_valid) begin
               r_tk  <= w_taken;
               r_ill <= w_illegal;
               r_mis <= w_mispred;
               r_npc <= w_taken ? (pc + imm) : (pc + c_four);
            end
         end

         assign w_ov  = r_v;
         assign w_tk  = r_tk;
         assign w_ill = r_ill;
         assign w_mis = r_mis;
         assign w_npc = r_npc;
      end else begin : g_two
         // Stage 1 resolves the condition; stage 2 forms the target address.
         logic         r_v1, r_tk1, r_ill1, r_mis1;
         logic [n-1:0] r_pc1, r_imm1;
         logic         r_v2, r_tk2, r_ill2, r_mis2;
         logic [n-1:0] r_npc2;
         logic         w_adv2;

         assign w_adv2 = !r_v2 || out_ready;
         assign w_adv1 = !r_v1 || w_adv2;

         always_ff @(posedge clock or negedge nReset) begin
            if (!nReset) begin
               r_v1 <= 1'b0;
               r_v2 <= 1'b0;
            end else if (flush) begin
               r_v1 <= 1'b0;
               r_v2 <= 1'b0;
            end else begin
               if (w_adv1) r_v1 <= in_valid;
               if (w_adv2) r_v2 <= r_v1;
            end
         end

         always_ff @(posedge clock) begin
            if (w_adv1 && in_valid) begin
               r_tk1  <= w_taken;
               r_ill1 <= w_illegal;
               r_mis1 <= w_mispred;
               r_pc1  <= pc;
               r_imm1 <= imm;
            end
            if (w_adv2 && r_v1) begin
               r_tk2  <= r_tk1;
               r_ill2 <= r_ill1;
               r_mis2 <= r_mis1;
               r_npc2 <= r_tk1 ? (r_pc1 + r_imm1) : (r_pc1 + c_four);
            end
         end

         assign w_ov  = r_v2;
         assign w_tk  = r_tk2;
         assign w_ill = r_ill2;
         assign w_mis = r_mis2;
         assign w_npc = r_npc2;
      end
   endgenerate

   assign in_ready   = w_adv1;
   assign out_valid  = w_ov;
   assign taken      = w_ov && w_tk;
   assign mispredict = w_ov && w_mis;
   assign illegal    = w_ov && w_ill;
   assign next_pc    = w_npc;
   assign w_retire   = w_ov && out_ready;

   // Retirement still counts in a flush cycle; counters stick at all-ones.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         r_br      <= '0;
         r_mis_cnt <= '0;
      end else if (w_retire) begin
         if (!w_ill && (r_br != c_max))     r_br      <= r_br + c_one;
         if (w_mis && (r_mis_cnt != c_max)) r_mis_cnt <= r_mis_cnt + c_one;
      end
   end

   assign br_count  = r_br;
   assign mis_count = r_mis_cnt;

endmodule

`default_nettype wire
